dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
Shares the single-ported data memory between two requesters: the CPU M-stage load/store port and the DMA/bridge port.
- Grants at most one access per cycle. Ties are broken round-robin.
- Supports bounded DMA bursts via a lock input.
- Suppresses writes with illegal byte enables and flags them.
- Produces the CPU stall and a contention counter.
- Sits between the M-stage and the memory, and drives the memory's Addr/Din/Be/We.

Parameters:
MAX_BURST, 4, maximum consecutive locked DMA grants while the CPU is waiting (range 1..15).
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request; held until granted
cpu_we  input  1  CPU write (1) / read (0)
cpu_addr  input  12  CPU word address [13:2]
cpu_wdata  input  32  CPU write data, lane-aligned as the memory expects
cpu_be  input  4  CPU byte enables
cpu_gnt  output  1  CPU access performed this cycle
cpu_rdata  output  32  memory Dout, valid when cpu_gnt
cpu_stall  output  1  cpu_req & ~cpu_gnt
dma_req, dma_we, dma_addr[11:0], dma_wdata[31:0], dma_be[3:0]  input  as CPU  DMA request bundle
dma_lock  input  1  DMA asks to keep ownership next cycle
dma_gnt  output  1  DMA access performed this cycle
dma_rdata  output  32  memory Dout, valid when dma_gnt
dm_addr  output  12  to memory Addr
dm_din  output  32  to memory Din
dm_be  output  4  to memory Be
dm_we  output  1  to memory We
dm_dout  input  32  from memory Dout (combinational read)
be_err  output  1  registered one-cycle pulse: previous granted write had illegal Be
stall_cnt  output  CNT_W  saturating count of cycles with cpu_stall=1

Behaviour:
- Grant is combinational from the current requests and registered state. A granted access completes at the rising edge ending the grant cycle.
- Zero added latency: a lone request is granted in the same cycle. Read data is passed straight from dm_dout.
- Registered state:
  - last_owner (reset DMA, so the CPU wins the first tie)
  - own_dma flag (reset 0)
  - burst_cnt, 4 bits (reset 0)
  - be_err (reset 0)
  - stall_cnt (reset 0)
- While Reset is high: cpu_gnt = dma_gnt = dm_we = 0; dm_addr/din/be are don't-care and driven 0.
- Arbitration, evaluated in order:
  1. own_dma=1 and dma_req=1 and (cpu_req=0 or burst_cnt<MAX_BURST): grant DMA.
  2. Exactly one requester: grant it.
  3. Both requesting: grant the one that is not last_owner.
  4. Neither requesting: no grant, dm_we=0.
- State updates:
  - On any grant, last_owner takes the granted requester.
  - own_dma next = dma_gnt & dma_lock.
  - burst_cnt next = own_dma_next ? burst_cnt+1 (saturating at 15) : 0.
- Lock boundaries:
  - A burst that reaches MAX_BURST while the CPU waits yields exactly one CPU grant. DMA must re-request; its lock restarts from 0.
  - A lock without a CPU request is unbounded.
  - Dropping dma_req releases ownership immediately.
- Mux: dm_addr/din/be come from the granted requester (CPU when idle).
- Legal Be set: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Illegal-Be write:
  - Only applies when the access is granted and is a write.
  - dm_we is forced to 0 and the grant is still given, so the requester is not hung.
  - be_err = 1 on the next cycle for one cycle.
- Reads ignore Be.
- stall_cnt increments each cycle cpu_stall=1 and saturates at all-ones.
- Reset asserted mid-burst clears own_dma/burst_cnt at once. After release, arbitration restarts with CPU priority on a tie.

Decomposition:
- Shared header holds:
  - the legal-Be code constants
  - the owner encoding (OWN_CPU=0, OWN_DMA=1)
  - MAX_BURST/CNT_W defaults
- One sub-module, dm_be_legal: combinational 4-bit Be to legal flag. It is reused by the M-stage store unit.

Test Plan:
- Lone CPU write, addr 0x010, be 1111, data 0xDEADBEEF -> same-cycle cpu_gnt=1, dm_we=1, cpu_stall=0; a following read of 0x010 returns 0xDEADBEEF.
- Tie: both request from reset, continuously -> grants alternate CPU, DMA, CPU, DMA; stall_cnt increments by 1 on each DMA-granted cycle.
- DMA locked burst of 6 with MAX_BURST=4 and cpu_req held -> DMA granted 4 cycles, CPU 1 cycle, then DMA again with burst_cnt restarted.
- CPU write with be=0101 -> cpu_gnt=1, dm_we=0, memory unchanged, be_err=1 for exactly the next cycle.
- Reset pulsed during cycle 2 of a DMA lock -> grants drop to 0 during reset; after release, simultaneous requests grant CPU first.
- CNT_W=4, CPU starved by repeated DMA ties/locks for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding,
// legal byte-enable codes and default parameter values.
package dm_arbiter_pkg;

  // Identity of the requester that last received a grant.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  // Byte-enable patterns the memory accepts: single bytes,
  // aligned half-words and the full word.
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU port, DMA port, memory port and status outputs
// of the data-memory arbiter.
interface dm_arbiter_if import dm_arbiter_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) ();

  // CPU M-stage port
  logic             cpu_req;
  logic             cpu_we;
  logic [11:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [3:0]       cpu_be;
  logic             cpu_gnt;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;

  // DMA / bridge port
  logic             dma_req;
  logic             dma_we;
  logic [11:0]      dma_addr;
  logic [31:0]      dma_wdata;
  logic [3:0]       dma_be;
  logic             dma_lock;
  logic             dma_gnt;
  logic [31:0]      dma_rdata;

  // Single-ported data memory
  logic [11:0]      dm_addr;
  logic [31:0]      dm_din;
  logic [3:0]       dm_be;
  logic             dm_we;
  logic [31:0]      dm_dout;

  // Status
  logic             be_err;
  logic [CNT_W-1:0] stall_cnt;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_lock,
    output dma_gnt, dma_rdata,
    output dm_addr, dm_din, dm_be, dm_we,
    input  dm_dout,
    output be_err, stall_cnt
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_lock,
    input  dma_gnt, dma_rdata,
    input  dm_addr, dm_din, dm_be, dm_we,
    output dm_dout,
    input  be_err, stall_cnt
  );

endinterface

// File: rtl/dm_be_legal.sv
// Byte-enable legality check: single byte, aligned half-word or full
// word. Shared with the M-stage store unit.
module dm_be_legal import dm_arbiter_pkg::*; (
  input  logic [3:0] i_be,
  output logic       o_legal
);

  // Match against the legal pattern list
  always_comb begin
    o_legal = 1'b0;
    case (i_be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: o_legal = 1'b1;
      default:                                        o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU M-stage and the DMA port.
// Same-cycle combinational grant, round-robin tie break, bounded
// DMA lock bursts, illegal byte-enable write suppression.
module dm_arbiter import dm_arbiter_pkg::*; #(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  dm_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  owner_e           r_last_owner;
  logic             r_own_dma;
  logic [3:0]       r_burst_cnt;
  logic             r_be_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_burst_hold;
  logic             w_cpu_gnt;
  logic             w_dma_gnt;
  logic             w_any_gnt;
  logic             w_sel_we;
  logic [3:0]       w_sel_be;
  logic             w_be_legal;
  logic             w_cpu_stall;
  logic             w_own_dma_next;
  logic [3:0]       w_burst_cnt_next;

  // A locked DMA keeps the port unless the CPU has waited a full burst.
  assign w_burst_hold = r_own_dma & bus.dma_req &
                        (~bus.cpu_req | (r_burst_cnt < MAX_BURST_C));

  // Grant selection: lock hold, then lone requester, then round-robin
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (!Reset) begin
      if (w_burst_hold) begin
        w_dma_gnt = 1'b1;
      end else if (bus.cpu_req && !bus.dma_req) begin
        w_cpu_gnt = 1'b1;
      end else if (bus.dma_req && !bus.cpu_req) begin
        w_dma_gnt = 1'b1;
      end else if (bus.cpu_req && bus.dma_req) begin
        if (r_last_owner == OWN_DMA) w_cpu_gnt = 1'b1;
        else                         w_dma_gnt = 1'b1;
      end
    end
  end

  assign w_any_gnt   = w_cpu_gnt | w_dma_gnt;
  assign w_sel_we    = w_dma_gnt ? bus.dma_we : bus.cpu_we;
  assign w_sel_be    = w_dma_gnt ? bus.dma_be : bus.cpu_be;
  assign w_cpu_stall = bus.cpu_req & ~w_cpu_gnt;

  dm_be_legal u_be_legal (
    .i_be    (w_sel_be),
    .o_legal (w_be_legal)
  );

  // Memory port mux; the CPU side is presented when idle, all zero in reset.
  assign bus.dm_addr = Reset ? 12'd0 : (w_dma_gnt ? bus.dma_addr  : bus.cpu_addr);
  assign bus.dm_din  = Reset ? 32'd0 : (w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata);
  assign bus.dm_be   = Reset ? 4'd0  : w_sel_be;
  // An illegal-Be write is still granted so the requester moves on.
  assign bus.dm_we   = w_any_gnt & w_sel_we & w_be_legal;

  assign bus.cpu_gnt   = w_cpu_gnt;
  assign bus.dma_gnt   = w_dma_gnt;
  assign bus.cpu_rdata = bus.dm_dout;
  assign bus.dma_rdata = bus.dm_dout;
  assign bus.cpu_stall = w_cpu_stall;
  assign bus.be_err    = r_be_err;
  assign bus.stall_cnt = r_stall_cnt;

  // Ownership continues only while DMA is granted and asking to lock.
  assign w_own_dma_next   = w_dma_gnt & bus.dma_lock;
  assign w_burst_cnt_next = !w_own_dma_next      ? 4'd0 :
                            (r_burst_cnt == 4'hF) ? 4'hF :
                                                    4'(r_burst_cnt + 4'd1);

  // Arbitration history: last owner, lock ownership and burst length
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last_owner <= OWN_DMA;
      r_own_dma    <= 1'b0;
      r_burst_cnt  <= 4'd0;
    end else begin
      if (w_any_gnt) r_last_owner <= w_dma_gnt ? OWN_DMA : OWN_CPU;
      r_own_dma   <= w_own_dma_next;
      r_burst_cnt <= w_burst_cnt_next;
    end
  end

  // Status: one-cycle illegal-Be flag and saturating CPU stall counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_be_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_be_err <= w_any_gnt & w_sel_we & ~w_be_legal;
      if (w_cpu_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
